// File: rtl/dsm_interp_feeder.sv
// dsm_interp_feeder: delta-sigma DAC front end. Accepts low-rate signed PCM
// samples over valid/ready and produces 2^OSR_LOG2 linearly interpolated
// sub-samples per input sample, each presented with a one-cycle step strobe
// (o_en) that paces the modulator.
// Optional build macro: DSM_FEEDER_ZOH_EN selects zero-order hold instead of
// linear interpolation; handshake, underrun and timing are unchanged.
module dsm_interp_feeder #(
  parameter int DATA_WIDTH = 4,
  parameter int OSR_LOG2   = 4,
  parameter int STEP_DIV   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_en,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_underrun,
  input  logic                  i_clr_underrun
);

  localparam int SW   = DATA_WIDTH + 1;             // step width
  localparam int AW   = DATA_WIDTH + 1 + OSR_LOG2;  // accumulator width
  localparam int DIVW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [DIVW-1:0]     DIV_LAST = DIVW'(STEP_DIV - 1);
  localparam logic [OSR_LOG2-1:0] PH_LAST  = {OSR_LOG2{1'b1}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] cur_q;
  logic [DATA_WIDTH-1:0] next_q;
  logic                  next_valid_q;
  logic [SW-1:0]         step_q;
  logic [AW-1:0]         acc_q;
  logic [OSR_LOG2-1:0]   phase_q;
  logic [DIVW-1:0]       div_cnt_q;
  logic                  en_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  underrun_q;

  logic                  en_next_s;
  logic                  wrap_s;
  logic                  xfer_s;
  logic [AW-1:0]         acc_inc_d;
  logic [AW-1:0]         bnd_acc_d;
  logic [SW-1:0]         bnd_step_d;
  logic [AW-1:0]         hold_acc_d;
  logic [AW-1:0]         start_acc_d;
  logic [SW-1:0]         start_step_d;

  // Sign-extend a sample to step width.
  function automatic logic [SW-1:0] sext_smp(input logic [DATA_WIDTH-1:0] x);
    return {x[DATA_WIDTH-1], x};
  endfunction

  // Sign-extend a step to accumulator width.
  function automatic logic [AW-1:0] sext_step(input logic [SW-1:0] s);
    return {{OSR_LOG2{s[SW-1]}}, s};
  endfunction

  // Sample scaled by OSR, in accumulator format.
  function automatic logic [AW-1:0] shl_osr(input logic [DATA_WIDTH-1:0] x);
    return {x[DATA_WIDTH-1], x, {OSR_LOG2{1'b0}}};
  endfunction

  // Step strobe, period boundary and handshake decode.
  always_comb begin
    en_next_s = (state_q == ST_RUN) && i_enable && (div_cnt_q == DIV_LAST);
    wrap_s    = en_next_s && (phase_q == PH_LAST);
    if (i_rst) begin
      o_ready = 1'b0;
    end else if (state_q == ST_IDLE) begin
      o_ready = 1'b1;
    end else begin
      o_ready = !next_valid_q || wrap_s;
    end
    xfer_s = i_valid && o_ready;
  end

  // Accumulator / step candidates for sub-sample advance, boundary and start.
  always_comb begin
    acc_inc_d = acc_q + sext_step(step_q);
`ifdef DSM_FEEDER_ZOH_EN
    bnd_step_d   = {SW{1'b0}};
    bnd_acc_d    = shl_osr(next_q);
    hold_acc_d   = shl_osr(cur_q);
    start_step_d = {SW{1'b0}};
    start_acc_d  = shl_osr(i_data);
`else
    bnd_step_d   = sext_smp(next_q) - sext_smp(cur_q);
    bnd_acc_d    = acc_inc_d;
    hold_acc_d   = acc_inc_d;
    start_step_d = sext_smp(i_data);
    start_acc_d  = {AW{1'b0}};
`endif
  end

  // Control FSM, interpolation datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      cur_q        <= {DATA_WIDTH{1'b0}};
      next_q       <= {DATA_WIDTH{1'b0}};
      next_valid_q <= 1'b0;
      step_q       <= {SW{1'b0}};
      acc_q        <= {AW{1'b0}};
      phase_q      <= {OSR_LOG2{1'b0}};
      div_cnt_q    <= {DIVW{1'b0}};
      en_q         <= 1'b0;
      data_q       <= {DATA_WIDTH{1'b0}};
      underrun_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          en_q   <= 1'b0;
          data_q <= {DATA_WIDTH{1'b0}};
          if (xfer_s) begin
            cur_q     <= i_data;
            acc_q     <= start_acc_d;
            step_q    <= start_step_d;
            phase_q   <= {OSR_LOG2{1'b0}};
            div_cnt_q <= {DIVW{1'b0}};
            state_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_enable) begin
            div_cnt_q <= (div_cnt_q == DIV_LAST) ? {DIVW{1'b0}} : div_cnt_q + DIVW'(1);
          end
          en_q <= en_next_s;
          if (en_next_s) begin
            // Present the current sub-sample (floor of acc / OSR), then advance.
            data_q  <= acc_q[OSR_LOG2 +: DATA_WIDTH];
            phase_q <= phase_q + OSR_LOG2'(1);
            if (phase_q == PH_LAST) begin
              if (next_valid_q) begin
                cur_q  <= next_q;
                step_q <= bnd_step_d;
                acc_q  <= bnd_acc_d;
              end else begin
                step_q <= {SW{1'b0}};
                acc_q  <= hold_acc_d;
              end
            end else begin
              acc_q <= acc_inc_d;
            end
          end
          // Refill beats consumption when both happen at a boundary.
          if (xfer_s) begin
            next_q       <= i_data;
            next_valid_q <= 1'b1;
          end else if (wrap_s) begin
            next_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      // Sticky underrun; a new underrun wins over a simultaneous clear.
      if (wrap_s && !next_valid_q) begin
        underrun_q <= 1'b1;
      end else if (i_clr_underrun) begin
        underrun_q <= 1'b0;
      end
    end
  end

  assign o_en       = en_q;
  assign o_data     = data_q;
  assign o_underrun = underrun_q;

endmodule
